// File: rtl/pc_seq_pkg.sv
// Shared types for the fetch-side PC sequencer: FSM state codes, redirect causes
// ranked by priority, and the sequential PC increment.
package pc_seq_pkg;

  typedef logic [1:0] state_t;
  localparam state_t BOOT  = 2'd0;
  localparam state_t FETCH = 2'd1;
  localparam state_t HOLD  = 2'd2;

  typedef enum logic [1:0] {
    RC_NONE = 2'd0,
    RC_BR   = 2'd1,
    RC_ERET = 2'd2,
    RC_EXC  = 2'd3
  } cause_t;

  localparam int PC_INC = 4;

  // A newer redirect replaces an older one on equal or higher priority.
  function automatic logic outranks(input cause_t newer, input cause_t older);
    return (newer != RC_NONE) && (newer >= older);
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// Single-entry redirect buffer: holds one cause+target while a fetch is
// outstanding; higher-or-equal priority overwrites, consume clears.
module pc_redirect_buf
  import pc_seq_pkg::*;
#(
  parameter int LENGTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  cause_t            cap_cause,
  input  logic [LENGTH-1:0] cap_target,
  input  logic              consume,
  output cause_t            buf_cause,
  output logic [LENGTH-1:0] buf_target
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_cause  <= RC_NONE;
      buf_target <= '0;
    end else if (consume) begin
      buf_cause  <= RC_NONE;
      buf_target <= '0;
    end else if (capture && outranks(cap_cause, buf_cause)) begin
      buf_cause  <= cap_cause;
      buf_target <= cap_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Drives the pc register's wr/pc_in/p_wr and the fetch handshake.
// Optional macro PC_SEQ_ALIGN_CHECK_EN turns misaligned branch targets into exceptions.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                LENGTH       = 32,
  parameter logic [LENGTH-1:0] RESET_VECTOR = 'h00001000,
  parameter logic [LENGTH-1:0] EXC_VECTOR   = 'h00002000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LENGTH-1:0] pc_q,
  output logic              fetch_req,
  input  logic              fetch_ack,
  input  logic              stall,
  input  logic              br_valid,
  input  logic [LENGTH-1:0] br_target,
  input  logic              exc_valid,
  input  logic [LENGTH-1:0] exc_pc,
  input  logic              eret_valid,
  output logic              pc_wr,
  output logic              pc_in_sel,
  output logic [LENGTH-1:0] pc_target,
  output logic [LENGTH-1:0] epc,
  output logic              in_exc,
  output logic              redirect_pending
);

  state_t            state, state_nxt;
  logic              align_fault;
  logic              exc_take;
  logic [LENGTH-1:0] exc_pc_eff;
  cause_t            in_cause, buf_cause, best_cause;
  logic [LENGTH-1:0] in_target, buf_target, best_target;
  logic              capture, consume;
  logic              wr, sel, req;
  logic [LENGTH-1:0] tgt;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign align_fault = br_valid && (br_target[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  // A real exception keeps its own faulting PC; an alignment fault blames pc_q.
  assign exc_take   = exc_valid || align_fault;
  assign exc_pc_eff = exc_valid ? exc_pc : pc_q;

  always_comb begin
    in_cause  = RC_NONE;
    in_target = '0;
    if (exc_take) begin
      in_cause  = RC_EXC;
      in_target = EXC_VECTOR;
    end else if (eret_valid && in_exc) begin
      in_cause  = RC_ERET;
      in_target = epc;
    end else if (br_valid) begin
      in_cause  = RC_BR;
      in_target = br_target;
    end
  end

  assign best_cause  = outranks(in_cause, buf_cause) ? in_cause  : buf_cause;
  assign best_target = outranks(in_cause, buf_cause) ? in_target : buf_target;

  pc_redirect_buf #(.LENGTH(LENGTH)) u_buf (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture),
    .cap_cause  (in_cause),
    .cap_target (in_target),
    .consume    (consume),
    .buf_cause  (buf_cause),
    .buf_target (buf_target)
  );

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    sel       = 1'b0;
    tgt       = '0;
    req       = 1'b0;
    capture   = 1'b0;
    consume   = 1'b0;
    case (state)
      BOOT: begin
        wr        = 1'b1;
        sel       = 1'b1;
        tgt       = RESET_VECTOR;
        state_nxt = FETCH;
      end
      FETCH: begin
        req = 1'b1;
        if (!fetch_ack) begin
          capture = (in_cause != RC_NONE);
        end else if (best_cause != RC_NONE) begin
          wr      = 1'b1;
          sel     = 1'b1;
          tgt     = best_target;
          consume = 1'b1;
        end else if (!stall) begin
          wr = 1'b1;
        end else begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (in_cause != RC_NONE) begin
          wr        = 1'b1;
          sel       = 1'b1;
          tgt       = in_target;
          state_nxt = FETCH;
        end else if (!stall) begin
          wr        = 1'b1;
          state_nxt = FETCH;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Outputs are forced low while reset is held, even though BOOT is the reset state.
  assign fetch_req        = reset & req;
  assign pc_wr            = reset & wr;
  assign pc_in_sel        = reset & sel;
  assign pc_target        = reset ? tgt : '0;
  assign redirect_pending = (buf_cause != RC_NONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= BOOT;
      epc    <= '0;
      in_exc <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FETCH || state == HOLD) begin
        if (in_cause == RC_EXC) begin
          epc    <= exc_pc_eff;
          in_exc <= 1'b1;
        end else if (in_cause == RC_ERET) begin
          in_exc <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer with a behavioural model of
// the sequencing rules and a stand-in pc register.
module tb_pc_sequencer;

  localparam logic [31:0] RV  = 32'h00001000;
  localparam logic [31:0] EXV = 32'h00002000;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_q;
  logic        fetch_req, fetch_ack, stall;
  logic        br_valid, exc_valid, eret_valid;
  logic [31:0] br_target, exc_pc;
  logic        pc_wr, pc_in_sel, in_exc, redirect_pending;
  logic [31:0] pc_target, epc;

  int checks = 0;
  int errors = 0;

  // model: mode 0=boot 1=fetch 2=hold, cause 0 none 1 br 2 eret 3 exc
  int          m_mode, m_pend, n_mode, n_pend;
  logic [31:0] m_pend_tgt, m_epc, m_pc, n_pend_tgt, n_epc;
  logic        m_in_exc, n_in_exc;
  logic        e_wr, e_sel, e_req;
  logic [31:0] e_tgt;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .pc_q             (pc_q),
    .fetch_req        (fetch_req),
    .fetch_ack        (fetch_ack),
    .stall            (stall),
    .br_valid         (br_valid),
    .br_target        (br_target),
    .exc_valid        (exc_valid),
    .exc_pc           (exc_pc),
    .eret_valid       (eret_valid),
    .pc_wr            (pc_wr),
    .pc_in_sel        (pc_in_sel),
    .pc_target        (pc_target),
    .epc              (epc),
    .in_exc           (in_exc),
    .redirect_pending (redirect_pending)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc_q <= '0;
    else if (pc_wr) pc_q <= pc_in_sel ? pc_target : pc_q + 32'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_ack = 0; stall = 0; br_valid = 0; br_target = '0;
    exc_valid = 0; exc_pc = '0; eret_valid = 0;
  endtask

  task automatic model_reset();
    m_mode = 0; m_pend = 0; m_pend_tgt = '0; m_epc = '0; m_in_exc = 0; m_pc = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fetch_req"}, {31'd0, fetch_req}, 32'd0);
    check({tag, "_pc_wr"}, {31'd0, pc_wr}, 32'd0);
    check({tag, "_pc_in_sel"}, {31'd0, pc_in_sel}, 32'd0);
    check({tag, "_pc_target"}, pc_target, 32'd0);
    check({tag, "_epc"}, epc, 32'd0);
    check({tag, "_in_exc"}, {31'd0, in_exc}, 32'd0);
    check({tag, "_pending"}, {31'd0, redirect_pending}, 32'd0);
  endtask

  // Expected outputs and next model state from the current inputs.
  task automatic model_eval();
    int          ic, lc;
    logic [31:0] it, lt;
    ic = 0; it = '0;
    if (exc_valid || (ALIGN && br_valid && br_target[1:0] != 2'b00)) begin
      ic = 3; it = EXV;
    end else if (eret_valid && m_in_exc) begin
      ic = 2; it = m_epc;
    end else if (br_valid) begin
      ic = 1; it = br_target;
    end
    n_mode = m_mode; n_pend = m_pend; n_pend_tgt = m_pend_tgt;
    n_epc = m_epc; n_in_exc = m_in_exc;
    e_wr = 0; e_sel = 0; e_tgt = '0; e_req = 0;
    if (m_mode == 0) begin
      e_wr = 1; e_sel = 1; e_tgt = RV; n_mode = 1;
    end else if (m_mode == 1) begin
      e_req = 1;
      if (!fetch_ack) begin
        if (ic != 0 && ic >= m_pend) begin n_pend = ic; n_pend_tgt = it; end
      end else begin
        if (ic != 0 && ic >= m_pend) begin lc = ic; lt = it; end
        else begin lc = m_pend; lt = m_pend_tgt; end
        if (lc != 0) begin
          e_wr = 1; e_sel = 1; e_tgt = lt; n_pend = 0; n_pend_tgt = '0;
        end else if (!stall) e_wr = 1;
        else n_mode = 2;
      end
    end else begin
      if (ic != 0) begin e_wr = 1; e_sel = 1; e_tgt = it; n_mode = 1; end
      else if (!stall) begin e_wr = 1; n_mode = 1; end
    end
    if (m_mode != 0) begin
      if (ic == 3) begin n_epc = exc_valid ? exc_pc : m_pc; n_in_exc = 1; end
      else if (ic == 2) n_in_exc = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic cycle();
    @(negedge clk);
    model_eval();
    check("fetch_req", {31'd0, fetch_req}, {31'd0, e_req});
    check("pc_wr", {31'd0, pc_wr}, {31'd0, e_wr});
    check("pc_in_sel", {31'd0, pc_in_sel}, {31'd0, e_sel});
    check("pc_target", pc_target, e_tgt);
    check("epc", epc, m_epc);
    check("in_exc", {31'd0, in_exc}, {31'd0, m_in_exc});
    check("pending", {31'd0, redirect_pending}, {31'd0, m_pend != 0});
    check("pc_q", pc_q, m_pc);
    @(posedge clk);
    if (e_wr) m_pc = e_sel ? e_tgt : m_pc + 32'd4;
    m_mode = n_mode; m_pend = n_pend; m_pend_tgt = n_pend_tgt;
    m_epc = n_epc; m_in_exc = n_in_exc;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_zero(tag);
    check({tag, "_pc_q"}, pc_q, 32'd0);
    model_reset();
    release_reset();
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_zero("reset");
    end
    release_reset();

    cycle();
    check("boot_pc_q", pc_q, RV);

    fetch_ack = 1;
    repeat (4) cycle();
    check("inc_pc_q", pc_q, 32'h1010);

    fetch_ack = 0; br_valid = 1; br_target = 32'hcacafff0;
    cycle();
    check("buffered_pending", {31'd0, redirect_pending}, 32'd1);
    br_valid = 0;
    cycle();
    fetch_ack = 1;
    cycle();
    check("buffered_load", pc_q, 32'hcacafff0);

    exc_valid = 1; exc_pc = 32'h1010; br_valid = 1; br_target = 32'h3000;
    cycle();
    check("exc_pc_q", pc_q, EXV);
    check("exc_epc", epc, 32'h1010);
    idle_inputs(); fetch_ack = 1;
    cycle();
    eret_valid = 1;
    cycle();
    check("eret_pc_q", pc_q, 32'h1010);
    check("eret_in_exc", {31'd0, in_exc}, 32'd0);

    eret_valid = 0; stall = 1;
    repeat (4) cycle();
    stall = 0;
    cycle();
    stall = 1;
    repeat (2) cycle();
    mid_cycle_reset("hold_reset");

    idle_inputs();
    cycle();
    fetch_ack = 1;
    cycle();
    check("align_setup_pc_q", pc_q, 32'h1004);
    br_valid = 1; br_target = 32'h1002;
    cycle();
    check("align_pc_q", pc_q, ALIGN ? EXV : 32'h1002);
    check("align_in_exc", {31'd0, in_exc}, {31'd0, ALIGN});
    check("align_epc", epc, ALIGN ? 32'h1004 : 32'h0);

    for (int i = 0; i < 400; i++) begin
      fetch_ack  = ($urandom_range(0, 3) != 0);
      stall      = ($urandom_range(0, 3) == 0);
      br_valid   = ($urandom_range(0, 4) == 0);
      br_target  = {$urandom(), 2'b00} | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
      exc_valid  = ($urandom_range(0, 11) == 0);
      exc_pc     = $urandom();
      eret_valid = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 99) == 0) begin
        idle_inputs();
        mid_cycle_reset("rand_reset");
      end else begin
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
